// File: rtl/mem_link_pkg.sv
// Shared definitions for the master/memory-controller FIFO link.
package mem_link_pkg;

    localparam int MEM_DATA_W    = 8;
    localparam int CMD_WRITE_BIT = 7;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD_CAP  = 3'd1,
        DATA_REQ = 3'd2,
        DATA_CAP = 3'd3,
        RD_MEM   = 3'd4,
        PUSH     = 3'd5
    } state_e;

    // A command byte with the top bit set carries a data byte behind it.
    function automatic logic is_write_cmd(input logic [MEM_DATA_W-1:0] cmd);
        return cmd[CMD_WRITE_BIT];
    endfunction

endpackage

// File: rtl/mem_ctrl_regfile.sv
// Small byte memory: async clear, one write port, one registered read port.
module mem_ctrl_regfile
    import mem_link_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [DATA_W-1:0]            rdata_q;

    // Storage array; reset wipes every byte so stale data never leaks out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register holds its value until the next read, so the response
    // byte stays stable while the controller waits on a full FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_ctrl_responder.sv
// Memory-controller side of the FIFO link: pops commands, executes them
// against the local regfile and pushes read results back.
module mem_ctrl_responder
    import mem_link_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk_mem,
    input  logic              reset_n,
    input  logic              fifo_empty,
    output logic              rd_en_mem,
    input  logic [DATA_W-1:0] data_out_mem,
    input  logic              fifo_full,
    output logic              wr_en_mem,
    output logic [DATA_W-1:0] data_in_mem,
    output logic              busy,
    output logic [7:0]        txn_count
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;
    logic [7:0]        txn_q, txn_d;
    logic              mem_we, mem_re;

    // Registered state, command address, FIFO strobes and transaction count.
    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            txn_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            txn_q   <= txn_d;
        end
    end

    // Next-state logic; strobes are computed one cycle early so the
    // FIFO sees clean registered pulses.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
        txn_d   = txn_q;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    rd_en_d = 1'b1;
                    state_d = CMD_CAP;
                end
            end
            CMD_CAP: begin
                // Reserved bits between the address and the write flag drop here.
                addr_d  = data_out_mem[ADDR_W-1:0];
                state_d = is_write_cmd(data_out_mem) ? DATA_REQ : RD_MEM;
            end
            DATA_REQ: begin
                if (!fifo_empty) begin
                    rd_en_d = 1'b1;
                    state_d = DATA_CAP;
                end
            end
            DATA_CAP: begin
                // Commit now so any later read sees the new byte.
                mem_we  = 1'b1;
                txn_d   = txn_q + 8'd1;
                state_d = IDLE;
            end
            RD_MEM: begin
                mem_re  = 1'b1;
                state_d = PUSH;
            end
            PUSH: begin
                if (!fifo_full) begin
                    wr_en_d = 1'b1;
                    txn_d   = txn_q + 8'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    mem_ctrl_regfile #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk_i   (clk_mem),
        .rst_ni  (reset_n),
        .we_i    (mem_we),
        .waddr_i (addr_q),
        .wdata_i (data_out_mem),
        .re_i    (mem_re),
        .raddr_i (addr_q),
        .rdata_o (data_in_mem)
    );

    assign rd_en_mem = rd_en_q;
    assign wr_en_mem = wr_en_q;
    assign busy      = (state_q != IDLE);
    assign txn_count = txn_q;

endmodule

// File: tb/tb_mem_ctrl_responder.sv
// Bench for mem_ctrl_responder: show-ahead request FIFO and response
// collector modelled with queues, byte memory modelled as a plain array.
`timescale 1ns/100ps
module tb_mem_ctrl_responder;

    localparam int AW = 4;

    logic       clk_mem = 1'b0;
    logic       reset_n;
    logic       fifo_empty;
    logic       rd_en_mem;
    logic [7:0] data_out_mem;
    logic       fifo_full;
    logic       wr_en_mem;
    logic [7:0] data_in_mem;
    logic       busy;
    logic [7:0] txn_count;

    mem_ctrl_responder #(.ADDR_W(AW), .DATA_W(8)) dut (
        .clk_mem      (clk_mem),
        .reset_n      (reset_n),
        .fifo_empty   (fifo_empty),
        .rd_en_mem    (rd_en_mem),
        .data_out_mem (data_out_mem),
        .fifo_full    (fifo_full),
        .wr_en_mem    (wr_en_mem),
        .data_in_mem  (data_in_mem),
        .busy         (busy),
        .txn_count    (txn_count)
    );

    always #8 clk_mem = ~clk_mem;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    // Bench state
    int         n_pass = 0, n_total = 0;
    int         cyc = 0;
    logic [7:0] reqq[$];
    logic [7:0] exp_q[$];
    int         rd_log[$], wr_log[$];
    logic [7:0] ref_mem [0:(1<<AW)-1];
    int         ref_txn = 0;
    logic       full_prev = 1'b0;
    logic [7:0] last_resp = 8'h00;
    int         resp_count = 0;

    typedef struct {
        logic       wr;
        logic [7:0] cmd;
        logic [7:0] dat;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic refresh();
        fifo_empty   = (reqq.size() == 0);
        data_out_mem = (reqq.size() != 0) ? reqq[0] : 8'h00;
    endtask

    task automatic push_raw(input logic [7:0] b);
        reqq.push_back(b);
        refresh();
    endtask

    // Queue a full command and predict its effect on the memory model.
    task automatic enqueue_cmd(input logic [7:0] cmd, input logic [7:0] dat);
        int a;
        a = cmd % (1 << AW);
        push_raw(cmd);
        if (cmd >= 8'h80) begin
            push_raw(dat);
            ref_mem[a] = dat;
        end else begin
            exp_q.push_back(ref_mem[a]);
        end
        ref_txn++;
    endtask

    task automatic handle_push(input logic [7:0] d);
        resp_count++;
        last_resp = d;
        wr_log.push_back(cyc);
        if (exp_q.size() == 0) chk("resp_unexpected", 1, 0);
        else chk("resp_data", d, exp_q.pop_front());
    endtask

    // One clock: sample strobes away from the edge, then apply FIFO effects.
    task automatic tick();
        logic p, w;
        logic [7:0] d;
        p = rd_en_mem;
        w = wr_en_mem;
        d = data_in_mem;
        chk("proto_underflow", int'(p && reqq.size() == 0), 0);
        chk("proto_overflow", int'(w && full_prev), 0);
        chk("proto_both", int'(p && w), 0);
        full_prev = fifo_full;
        @(posedge clk_mem);
        #1;
        if (p && reqq.size() != 0) begin
            void'(reqq.pop_front());
            rd_log.push_back(cyc);
        end
        if (w) handle_push(d);
        refresh();
        @(negedge clk_mem);
        cyc++;
    endtask

    task automatic run_idle(input string name, input int max);
        int n;
        n = 0;
        while (!(reqq.size() == 0 && !busy && !wr_en_mem && !rd_en_mem) && n < max) begin
            tick();
            n++;
        end
        chk(name, int'(n < max), 1);
    endtask

    task automatic model_reset();
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 8'h00;
        ref_txn = 0;
        exp_q.delete();
        reqq.delete();
        full_prev = 1'b0;
        refresh();
    endtask

    initial begin
        int t0, rc;
        logic [7:0] c, dd;

        tbl[0] = '{1'b1, 8'h81, 8'h11, 8'h00};
        tbl[1] = '{1'b0, 8'h01, 8'h00, 8'h11};
        tbl[2] = '{1'b1, 8'h8F, 8'hC3, 8'h00};
        tbl[3] = '{1'b0, 8'h7F, 8'h00, 8'hC3};
        tbl[4] = '{1'b1, 8'hF0, 8'h5A, 8'h00};
        tbl[5] = '{1'b0, 8'h30, 8'h00, 8'h5A};
        tbl[6] = '{1'b1, 8'h81, 8'hEE, 8'h00};
        tbl[7] = '{1'b0, 8'h41, 8'h00, 8'hEE};
        tbl[8] = '{1'b0, 8'h0F, 8'h00, 8'hC3};
        tbl[9] = '{1'b0, 8'h04, 8'h00, 8'h00};

        // Reset with a read of address 3 already waiting
        reset_n   = 1'b0;
        fifo_full = 1'b0;
        model_reset();
        @(negedge clk_mem);
        enqueue_cmd(8'h03, 8'h00);
        tick();
        tick();
        chk("rst_rd_en", rd_en_mem, 0);
        chk("rst_wr_en", wr_en_mem, 0);
        chk("rst_busy", busy, 0);
        chk("rst_txn", txn_count, 0);
        chk("rst_data_in", data_in_mem, 0);
        reset_n = 1'b1;
        run_idle("rst_read_timeout", 50);
        chk("rst_read_val", last_resp, 8'h00);
        chk("rst_read_txn", txn_count, 1);

        // Table of single commands
        for (int i = 0; i < 10; i++) begin
            rc = resp_count;
            enqueue_cmd(tbl[i].cmd, tbl[i].dat);
            run_idle("tbl_timeout", 50);
            if (!tbl[i].wr) begin
                chk("tbl_resp_count", resp_count - rc, 1);
                chk("tbl_read_val", last_resp, tbl[i].exp);
            end else begin
                chk("tbl_write_no_resp", resp_count - rc, 0);
            end
            chk("tbl_txn", txn_count, ref_txn & 255);
        end

        // Write then read, all bytes queued at once; check timing
        rd_log.delete();
        wr_log.delete();
        t0 = ref_txn;
        enqueue_cmd(8'h85, 8'hA5);
        enqueue_cmd(8'h05, 8'h00);
        run_idle("wr_rd_timeout", 50);
        chk("wr_rd_pops", rd_log.size(), 3);
        chk("wr_rd_pushes", wr_log.size(), 1);
        if (rd_log.size() == 3 && wr_log.size() == 1) begin
            chk("wr_data_pop_lat", rd_log[1] - rd_log[0], 2);
            chk("wr_spacing", rd_log[2] - rd_log[0], 4);
            chk("rd_push_lat", wr_log[0] - rd_log[2], 3);
        end
        chk("wr_rd_val", last_resp, 8'hA5);
        chk("wr_rd_txn", txn_count, (t0 + 2) & 255);

        // Empty stall: write command with its data byte withheld
        rd_log.delete();
        t0 = ref_txn;
        push_raw(8'h82);
        repeat (20) tick();
        chk("empty_busy", busy, 1);
        chk("empty_pops", rd_log.size(), 1);
        chk("empty_txn", txn_count, t0 & 255);
        push_raw(8'h3C);
        ref_mem[2] = 8'h3C;
        ref_txn++;
        run_idle("empty_timeout", 50);
        chk("empty_pops_after", rd_log.size(), 2);
        enqueue_cmd(8'h02, 8'h00);
        run_idle("empty_rd_timeout", 50);
        chk("empty_rd_val", last_resp, 8'h3C);

        // Full stall: read result held while the response FIFO is full
        rc = resp_count;
        fifo_full = 1'b1;
        enqueue_cmd(8'h02, 8'h00);
        repeat (4) tick();
        for (int i = 0; i < 10; i++) begin
            chk("full_wr_en", wr_en_mem, 0);
            chk("full_data_hold", data_in_mem, 8'h3C);
            tick();
        end
        chk("full_busy", busy, 1);
        chk("full_no_push", resp_count - rc, 0);
        fifo_full = 1'b0;
        run_idle("full_timeout", 50);
        chk("full_one_push", resp_count - rc, 1);
        chk("full_val", last_resp, 8'h3C);

        // Randomized mix with random back-pressure
        for (int i = 0; i < 60; i++) begin
            c  = 8'($urandom_range(0, 255));
            dd = 8'($urandom_range(0, 255));
            enqueue_cmd(c, dd);
            repeat ($urandom_range(0, 6)) begin
                fifo_full = ($urandom_range(0, 3) == 0);
                tick();
            end
        end
        fifo_full = 1'b0;
        run_idle("rand_timeout", 3000);
        chk("rand_all_resp", exp_q.size(), 0);
        chk("rand_txn", txn_count, ref_txn & 255);

        // Reset in the middle of a write
        push_raw(8'h87);
        repeat (4) tick();
        chk("midrst_pre_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_rd_en", rd_en_mem, 0);
        chk("midrst_wr_en", wr_en_mem, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_txn", txn_count, 0);
        chk("midrst_data_in", data_in_mem, 0);
        model_reset();
        tick();
        tick();
        reset_n = 1'b1;
        enqueue_cmd(8'h07, 8'h00);
        run_idle("midrst_rd_timeout", 50);
        chk("midrst_rd_val", last_resp, 8'h00);
        chk("midrst_rd_txn", txn_count, 1);

        // Counter wrap: 256 reads in total since the reset
        rd_log.delete();
        for (int i = 0; i < 254; i++) enqueue_cmd(8'($urandom_range(0, 127)), 8'h00);
        run_idle("wrap_timeout", 2000);
        chk("wrap_255", txn_count, 255);
        chk("wrap_b2b_spacing", rd_log[253] - rd_log[0], 4 * 253);
        enqueue_cmd(8'h7F, 8'h00);
        run_idle("wrap_last_timeout", 50);
        chk("wrap_0", txn_count, 0);
        chk("wrap_all_resp", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
